// File: rtl/fifo_pkg.sv
// Shared async-FIFO definitions: pointer Gray helpers, controller state enum, default address width.
package fifo_pkg;

  localparam int FIFO_ADDR_W = 4;

  typedef enum logic [1:0] {
    INIT  = 2'd0,
    RUN   = 2'd1,
    FLUSH = 2'd2
  } fifo_state_e;

  function automatic logic [31:0] bin2gray(input logic [31:0] b);
    return b ^ (b >> 1);
  endfunction

  // Prefix XOR from the MSB down, done in log2 steps.
  function automatic logic [31:0] gray2bin(input logic [31:0] g);
    logic [31:0] b;
    b = g;
    b = b ^ (b >> 1);
    b = b ^ (b >> 2);
    b = b ^ (b >> 4);
    b = b ^ (b >> 8);
    b = b ^ (b >> 16);
    return b;
  endfunction

endpackage

// File: rtl/gray2bin_conv.sv
// Combinational Gray-to-binary converter, shared by the read- and write-side FIFO controllers.
module gray2bin_conv #(
  parameter int WIDTH = 5
) (
  input  logic [WIDTH-1:0] gray_i,
  output logic [WIDTH-1:0] bin_o
);

  for (genvar i = 0; i < WIDTH; i++) begin : g_bit
    assign bin_o[i] = ^(gray_i >> i);
  end

endmodule

// File: rtl/fifo_rd_ctrl.sv
// Async FIFO read-side controller (clk_B): read pointer, empty, pop handshake, flush.
// Optional registered occupancy output via macro FIFO_RD_LEVEL_EN (rd_level tied to 0 otherwise).
module fifo_rd_ctrl
  import fifo_pkg::*;
#(
  parameter int ADDR_W      = FIFO_ADDR_W,
  parameter int SYNC_STAGES = 2
) (
  input  logic              clk_B,
  input  logic              rst,
  input  logic              en,
  input  logic [ADDR_W:0]   wptr_gray_sync,
  input  logic              rd_en,
  input  logic              flush,
  output logic [ADDR_W-1:0] rd_addr,
  output logic [ADDR_W:0]   rptr_gray,
  output logic              empty,
  output logic              rd_valid,
  output logic              underflow,
  output logic [ADDR_W:0]   rd_level
);
  // state | meaning
  // INIT  | synchronizer warm-up; empty forced, pops refused
  // RUN   | normal pop handling and empty tracking
  // FLUSH | one settle cycle after jumping the read pointer to the write pointer

  localparam int PTR_W = ADDR_W + 1;
  localparam int CNT_W = (SYNC_STAGES > 1) ? $clog2(SYNC_STAGES) : 1;
  localparam logic [CNT_W-1:0] WARM_LAST = CNT_W'(SYNC_STAGES - 1);

  fifo_state_e      state_q, state_d;
  logic [CNT_W-1:0] warm_cnt_q, warm_cnt_d;
  logic [PTR_W-1:0] rbin_q, rbin_d;
  logic [PTR_W-1:0] rptr_gray_q, rptr_gray_d;
  logic             empty_q, empty_d;
  logic             rd_valid_q, rd_valid_d;
  logic             underflow_q, underflow_d;
  logic [PTR_W-1:0] wbin;
  logic [PTR_W-1:0] rbin_next;
  logic [PTR_W-1:0] rgray_next;
  logic             pop;

  gray2bin_conv #(.WIDTH(PTR_W)) u_wptr_g2b (
    .gray_i (wptr_gray_sync),
    .bin_o  (wbin)
  );

  assign pop        = (state_q == RUN) && rd_en && !empty_q && !flush;
  assign rbin_next  = pop ? rbin_q + PTR_W'(1) : rbin_q;
  assign rgray_next = PTR_W'(bin2gray(32'(rbin_next)));

  always_ff @(posedge clk_B or posedge rst) begin
    if (rst) begin
      state_q    <= INIT;
      warm_cnt_q <= '0;
    end else if (en) begin
      state_q    <= state_d;
      warm_cnt_q <= warm_cnt_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    warm_cnt_d = warm_cnt_q;
    unique case (state_q)
      INIT: begin
        if (warm_cnt_q == WARM_LAST) state_d = RUN;
        else                         warm_cnt_d = warm_cnt_q + CNT_W'(1);
      end
      RUN:     if (flush) state_d = FLUSH;
      FLUSH:   state_d = RUN;
      default: state_d = INIT;
    endcase
  end

  always_comb begin
    rbin_d      = rbin_q;
    rptr_gray_d = rptr_gray_q;
    empty_d     = 1'b1;
    rd_valid_d  = 1'b0;
    underflow_d = underflow_q;
    if (state_q == RUN) begin
      if (flush) begin
        rbin_d      = wbin;
        rptr_gray_d = wptr_gray_sync;
        underflow_d = 1'b0;
      end else begin
        rbin_d      = rbin_next;
        rptr_gray_d = rgray_next;
        empty_d     = (rgray_next == wptr_gray_sync);
        rd_valid_d  = pop;
        if (rd_en && empty_q) underflow_d = 1'b1;
      end
    end
  end

  always_ff @(posedge clk_B or posedge rst) begin
    if (rst) begin
      rbin_q      <= '0;
      rptr_gray_q <= '0;
      empty_q     <= 1'b1;
      rd_valid_q  <= 1'b0;
      underflow_q <= 1'b0;
    end else if (en) begin
      rbin_q      <= rbin_d;
      rptr_gray_q <= rptr_gray_d;
      empty_q     <= empty_d;
      rd_valid_q  <= rd_valid_d;
      underflow_q <= underflow_d;
    end
  end

`ifdef FIFO_RD_LEVEL_EN
  logic [PTR_W-1:0] rd_level_q, rd_level_d;

  always_comb begin
    rd_level_d = '0;
    if (state_q == RUN && !flush) rd_level_d = wbin - rbin_next;
  end

  always_ff @(posedge clk_B or posedge rst) begin
    if (rst)     rd_level_q <= '0;
    else if (en) rd_level_q <= rd_level_d;
  end

  assign rd_level = rd_level_q;
`else
  assign rd_level = '0;
`endif

  assign rd_addr   = rbin_q[ADDR_W-1:0];
  assign rptr_gray = rptr_gray_q;
  assign empty     = empty_q;
  assign rd_valid  = rd_valid_q;
  assign underflow = underflow_q;

endmodule

// File: tb/tb_fifo_rd_ctrl.sv
// Self-checking bench for fifo_rd_ctrl: vector table for warm-up/pop basics, scoreboard of
// expected read addresses, and hand-written sequences for wrap, freeze, reset and flush.
module tb_fifo_rd_ctrl;

`ifdef FIFO_RD_LEVEL_EN
  localparam bit LVL_EN = 1'b1;
`else
  localparam bit LVL_EN = 1'b0;
`endif

  logic       clk_B = 1'b0;
  logic       rst, en, rd_en, flush;
  logic [4:0] wptr;
  logic [3:0] rd_addr;
  logic [4:0] rptr_gray, rd_level;
  logic       empty, rd_valid, underflow;

  int n_chk  = 0;
  int n_fail = 0;
  logic [3:0] sb[$];

  fifo_rd_ctrl #(.ADDR_W(4), .SYNC_STAGES(2)) dut (
    .clk_B          (clk_B),
    .rst            (rst),
    .en             (en),
    .wptr_gray_sync (wptr),
    .rd_en          (rd_en),
    .flush          (flush),
    .rd_addr        (rd_addr),
    .rptr_gray      (rptr_gray),
    .empty          (empty),
    .rd_valid       (rd_valid),
    .underflow      (underflow),
    .rd_level       (rd_level)
  );

  always #5 clk_B = ~clk_B;

  typedef struct {
    logic       rd_en;
    logic [4:0] wbin;
    logic       pop;
    logic       empty;
    logic       rdv;
    logic       uf;
    logic [3:0] addr;
    logic [4:0] rptr;
    logic [4:0] lvl;
  } vec_t;

  vec_t vecs[10];

  function automatic vec_t mk(input logic re, input logic [4:0] wb, input logic p,
                              input logic e, input logic v, input logic u,
                              input logic [3:0] a, input logic [4:0] r, input logic [4:0] l);
    vec_t t;
    t.rd_en = re; t.wbin = wb; t.pop = p; t.empty = e; t.rdv = v; t.uf = u;
    t.addr = a; t.rptr = r; t.lvl = l;
    return t;
  endfunction

  function automatic logic [4:0] g(input logic [4:0] b);
    return b ^ (b >> 1);
  endfunction

  function automatic logic [4:0] lx(input logic [4:0] v);
    return LVL_EN ? v : 5'd0;
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", nm, act, exp);
    end
  endtask

  task automatic chk_all(input string nm, input logic [3:0] a, input logic [4:0] r,
                         input logic e, input logic v, input logic u, input logic [4:0] l);
    chk({nm, ".rd_addr"},   32'(rd_addr),   32'(a));
    chk({nm, ".rptr_gray"}, 32'(rptr_gray), 32'(r));
    chk({nm, ".empty"},     32'(empty),     32'(e));
    chk({nm, ".rd_valid"},  32'(rd_valid),  32'(v));
    chk({nm, ".underflow"}, 32'(underflow), 32'(u));
    chk({nm, ".rd_level"},  32'(rd_level),  32'(lx(l)));
  endtask

  // Compare the address about to be popped against the oldest written entry.
  task automatic sb_check(input string nm);
    logic [3:0] e;
    if (sb.size() == 0) begin
      n_chk++;
      n_fail++;
      $display("FAIL %s: got pop at %0h, expected no entry pending", nm, rd_addr);
    end else begin
      e = sb.pop_front();
      chk(nm, 32'(rd_addr), 32'(e));
    end
  endtask

  task automatic step();
    @(posedge clk_B);
    #1;
  endtask

  initial begin
    vec_t       v;
    logic [4:0] prev_wb, rb, wb;
    logic       exp_empty, re, pop_e, wr;
    int         written;

    //            re    wbin  pop   empty rdv   uf    addr  rptr      lvl
    vecs[0] = mk(1'b1, 5'd0, 1'b0, 1'b1, 1'b0, 1'b0, 4'd0, 5'b00000, 5'd0);
    vecs[1] = mk(1'b1, 5'd0, 1'b0, 1'b1, 1'b0, 1'b0, 4'd0, 5'b00000, 5'd0);
    vecs[2] = mk(1'b1, 5'd0, 1'b0, 1'b1, 1'b0, 1'b1, 4'd0, 5'b00000, 5'd0);
    vecs[3] = mk(1'b1, 5'd0, 1'b0, 1'b1, 1'b0, 1'b1, 4'd0, 5'b00000, 5'd0);
    vecs[4] = mk(1'b1, 5'd0, 1'b0, 1'b1, 1'b0, 1'b1, 4'd0, 5'b00000, 5'd0);
    vecs[5] = mk(1'b0, 5'd3, 1'b0, 1'b0, 1'b0, 1'b1, 4'd0, 5'b00000, 5'd3);
    vecs[6] = mk(1'b1, 5'd3, 1'b1, 1'b0, 1'b1, 1'b1, 4'd1, 5'b00001, 5'd2);
    vecs[7] = mk(1'b1, 5'd3, 1'b1, 1'b0, 1'b1, 1'b1, 4'd2, 5'b00011, 5'd1);
    vecs[8] = mk(1'b1, 5'd3, 1'b1, 1'b1, 1'b1, 1'b1, 4'd3, 5'b00010, 5'd0);
    vecs[9] = mk(1'b0, 5'd3, 1'b0, 1'b1, 1'b0, 1'b1, 4'd3, 5'b00010, 5'd0);

    rst = 1'b1; en = 1'b1; rd_en = 1'b0; flush = 1'b0; wptr = 5'd0;
    repeat (3) step();
    chk_all("reset", 4'd0, 5'd0, 1'b1, 1'b0, 1'b0, 5'd0);
    rst = 1'b0;

    // Warm-up with constant pop requests, then three back-to-back pops.
    prev_wb = 5'd0;
    for (int i = 0; i < 10; i++) begin
      v = vecs[i];
      for (int k = int'(prev_wb); k < int'(v.wbin); k++) sb.push_back(4'(k));
      prev_wb = v.wbin;
      rd_en = v.rd_en;
      wptr  = g(v.wbin);
      if (v.pop) sb_check($sformatf("vec%0d.pop_addr", i));
      step();
      chk_all($sformatf("vec%0d", i), v.addr, v.rptr, v.empty, v.rdv, v.uf, v.lvl);
    end

    // Random fill/drain of 40 entries across the full pointer wrap.
    rb = 5'd3; wb = 5'd3; exp_empty = 1'b1; written = 0;
    for (int cyc = 0; cyc < 1000 && !(written == 40 && rb == wb); cyc++) begin
      wr = (written < 40) && (5'(wb - rb) < 5'd16) && ($urandom_range(0, 2) != 0);
      if (wr) begin
        sb.push_back(wb[3:0]);
        wb = wb + 5'd1;
        written++;
      end
      re    = ($urandom_range(0, 3) != 0);
      pop_e = re && !exp_empty;
      wptr  = g(wb);
      rd_en = re;
      if (pop_e) sb_check("wrap.pop_addr");
      step();
      if (pop_e) rb = rb + 5'd1;
      exp_empty = (rb == wb);
      chk("wrap.rd_valid",  32'(rd_valid),  32'(pop_e));
      chk("wrap.empty",     32'(empty),     32'(exp_empty));
      chk("wrap.rd_addr",   32'(rd_addr),   32'(rb[3:0]));
      chk("wrap.rptr_gray", 32'(rptr_gray), 32'(g(rb)));
      chk("wrap.rd_level",  32'(rd_level),  32'(lx(5'(wb - rb))));
    end
    rd_en = 1'b0;
    chk("wrap.final_addr", 32'(rd_addr),   32'd11);
    chk("wrap.final_rptr", 32'(rptr_gray), 32'(5'b01110));

    // Write pointer 16 ahead: pointers differ only in the wrap bit.
    for (int k = 0; k < 16; k++) sb.push_back(4'(11 + k));
    wptr = g(5'd27);
    step();
    chk_all("full16", 4'd11, 5'b01110, 1'b0, 1'b0, 1'b1, 5'd16);

    // One pop, then en low for 4 cycles with a pending pop: everything holds.
    rd_en = 1'b1;
    sb_check("freeze.pop_addr0");
    step();
    chk_all("freeze.pre", 4'd12, 5'b01010, 1'b0, 1'b1, 1'b1, 5'd15);
    en = 1'b0;
    for (int k = 0; k < 4; k++) begin
      step();
      chk_all($sformatf("freeze.c%0d", k), 4'd12, 5'b01010, 1'b0, 1'b1, 1'b1, 5'd15);
    end
    en = 1'b1;
    sb_check("freeze.pop_addr1");
    step();
    chk_all("freeze.resume", 4'd13, 5'b01011, 1'b0, 1'b1, 1'b1, 5'd14);
    rd_en = 1'b0;
    step();
    chk_all("freeze.idle", 4'd13, 5'b01011, 1'b0, 1'b0, 1'b1, 5'd14);

    // Asynchronous reset mid-operation, warm-up restart, then flush.
    rst = 1'b1;
    #2;
    chk_all("midreset", 4'd0, 5'd0, 1'b1, 1'b0, 1'b0, 5'd0);
    sb.delete();
    wptr = 5'd0; rd_en = 1'b1;
    step();
    step();
    rst = 1'b0;
    step();
    chk_all("rewarm.c1", 4'd0, 5'd0, 1'b1, 1'b0, 1'b0, 5'd0);
    step();
    chk_all("rewarm.c2", 4'd0, 5'd0, 1'b1, 1'b0, 1'b0, 5'd0);
    step();
    chk_all("rewarm.uf", 4'd0, 5'd0, 1'b1, 1'b0, 1'b1, 5'd0);
    rd_en = 1'b0;
    wptr  = g(5'd9);
    for (int k = 0; k < 9; k++) sb.push_back(4'(k));
    step();
    chk_all("flush.avail", 4'd0, 5'd0, 1'b0, 1'b0, 1'b1, 5'd9);
    rd_en = 1'b1;
    sb_check("flush.pop_addr0");
    step();
    chk_all("flush.pop0", 4'd1, 5'b00001, 1'b0, 1'b1, 1'b1, 5'd8);
    sb_check("flush.pop_addr1");
    step();
    chk_all("flush.pop1", 4'd2, 5'b00011, 1'b0, 1'b1, 1'b1, 5'd7);
    flush = 1'b1;
    step();
    chk_all("flush.entry", 4'd9, 5'b01101, 1'b1, 1'b0, 1'b0, 5'd0);
    sb.delete();
    flush = 1'b0;
    step();
    chk_all("flush.hold", 4'd9, 5'b01101, 1'b1, 1'b0, 1'b0, 5'd0);
    step();
    chk_all("flush.run_uf", 4'd9, 5'b01101, 1'b1, 1'b0, 1'b1, 5'd0);
    rd_en = 1'b0;
    wptr  = g(5'd10);
    sb.push_back(4'd9);
    step();
    chk_all("flush.newdata", 4'd9, 5'b01101, 1'b0, 1'b0, 1'b1, 5'd1);
    rd_en = 1'b1;
    sb_check("flush.pop_addr2");
    step();
    chk_all("flush.pop2", 4'd10, 5'b01111, 1'b1, 1'b1, 1'b1, 5'd0);
    rd_en = 1'b0;
    step();

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
